irig_enc_stream_arbiter: RTL and testbench
==========================================

# irig_enc_stream_arbiter

Shares one 32-bit AXI-Stream DMA channel between two sources. The first source is decoded IRIG-B frames from the B002 decoder: 164 bits, `{sync_edge[63:0], irig_bits[99:0]}`. The second source is encoder timestamp samples. Each accepted item is buffered, framed with a header word, serialized into 32-bit beats and emitted as one AXI-Stream packet. When both sources are pending, a round-robin scheduler chooses between them at packet boundaries. The IRIG source ignores backpressure, so this block counts any IRIG frames it has to drop.

## Interface
Parameters:
- None. Widths are fixed by the decoder frame format and the DMA width.

Ports:
- `clk_50MHz`  in  1  system clock. All logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `s_irig_tdata`  in  164  decoded IRIG frame.
- `s_irig_tvalid`  in  1  one-cycle frame strobe. The source does not wait for `s_irig_tready`.
- `s_irig_tready`  out  1  high when the IRIG buffer is empty.
- `s_enc_tdata`  in  96  encoder sample, `{timestamp[63:0], enc_count[31:0]}`.
- `s_enc_tvalid`  in  1  standard AXI-Stream valid.
- `s_enc_tready`  out  1  high when the encoder buffer is empty.
- `m_axis_tdata`  out  32  output beat.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tlast`  out  1  high on the last beat of a packet.
- `irig_drop_count`  out  16  number of IRIG frames lost because the buffer was full. Saturates at 0xFFFF.

## Operation
- **IRIG buffer:** 164-bit register plus `irig_full` flag.
  - `s_irig_tready = ~irig_full`.
  - `s_irig_tvalid & ~irig_full` captures the frame and sets `irig_full`.
  - `s_irig_tvalid & irig_full` discards the frame, leaves the buffer unchanged and increments `irig_drop_count` (saturating).
- **Encoder buffer:** 96-bit register plus `enc_full`.
  - `s_enc_tready = ~enc_full`.
  - The buffer loads on the handshake. No data is dropped.
- **FSM states:** IDLE, SEND_IRIG, SEND_ENC. A 3-bit beat index `idx` tracks position within a packet.
- **IDLE:**
  - Only `irig_full` set: go to SEND_IRIG.
  - Only `enc_full` set: go to SEND_ENC.
  - Both set: grant the source not granted last, using `last_grant`. Reset value of `last_grant` is ENC, so IRIG wins the first tie.
  - On every grant: `idx <= 0` and `last_grant` is updated.
- **SEND_IRIG packet:** 7 beats, in this order:
  - idx0: header 0xA100_0006
  - idx1: tdata[31:0]
  - idx2: tdata[63:32]
  - idx3: tdata[95:64]
  - idx4: tdata[127:96]
  - idx5: tdata[159:128]
  - idx6: {28'b0, tdata[163:160]}, with `tlast`
- **SEND_ENC packet:** 4 beats, in this order:
  - idx0: header 0xE100_0003
  - idx1: enc_count
  - idx2: timestamp[31:0]
  - idx3: timestamp[63:32], with `tlast`
- **Beat advance:** on each `m_axis_tvalid & m_axis_tready`, `idx` increments.
- **Packet end:** the `tlast` handshake clears the granted buffer's full flag and returns the FSM to IDLE.
- **Buffer stability:** the granted buffer never changes during its packet. The other buffer may fill at any time.
- **Output driving:** `m_axis_tvalid = (state != IDLE)`. `tdata` and `tlast` are decoded from `state`, `idx` and the buffer registers only. There is no combinational path from any input port to any output.

## Timing
- **Reset values:**
  - `state` = IDLE, `idx` = 0, `last_grant` = ENC.
  - `irig_full` = 0 and `enc_full` = 0.
  - `s_irig_tready` = 1, `s_enc_tready` = 1 (both effective the cycle after reset deasserts).
  - `m_axis_tvalid` = 0, `m_axis_tlast` = 0, `m_axis_tdata` = 0.
  - `irig_drop_count` = 0.
- **Latency:** input capture at edge N sets the full flag at N. The grant happens at edge N+1. The header beat is valid in the cycle after edge N+1, i.e. 2 cycles after capture.
- **Throughput:**
  - IRIG packet: 7 beats, plus 1 IDLE cycle between packets.
  - Encoder packet: 4 beats, plus 1 IDLE cycle between packets.
- **Backpressure:** while `m_axis_tready` is low, `tdata`, `tlast` and `tvalid` are held stable.
- **Buffer release:** the full flag clears at the `tlast` handshake edge. `s_*_tready` rises in the following cycle. A `s_irig_tvalid` in the same cycle as that `tlast` handshake sees `tready` = 0 and is dropped and counted.
- **Reset mid-packet:** the packet is abandoned with no `tlast`. `tvalid` is low in the cycle after the reset edge. Both buffers are emptied.
- **Simultaneous input capture:** IRIG and encoder captures in the same cycle are independent. Arbitration follows `last_grant`.

## Test plan
- **Single IRIG frame:** one IRIG frame with tdata = 164'h5_0123456789ABCDEF_00112233_44556677_8899AABB, `m_axis_tready` = 1.
  - Expect beats A1000006, 8899AABB, 44556677, 00112233, 89ABCDEF, 01234567, 00000005.
  - Expect `tlast` on beat 7 only and the header valid 2 cycles after the strobe.
- **Single encoder sample:** timestamp = 0x0000_0001_8000_0000, enc_count = 0x12345678.
  - Expect beats E1000003, 12345678, 80000000, 00000001.
  - Expect `s_enc_tready` low from capture until the cycle after `tlast`.
- **Simultaneous capture after reset:** IRIG and encoder captured in the same cycle.
  - Expect the IRIG packet first, then the encoder packet.
  - Repeat with both captured together again: now the encoder packet goes first (round-robin).
- **IRIG drop:** two IRIG strobes 3 cycles apart with `m_axis_tready` = 0.
  - Expect the first frame emitted intact once ready rises.
  - Expect `irig_drop_count` = 1.
- **Backpressure:** toggle `m_axis_tready` pseudo-randomly over 1000 packets.
  - Expect no lost beats and stable data while stalled.
  - Expect the drop counter to saturate at 0xFFFF under sustained overflow.
- **Reset mid-packet:** assert `reset` during beat 3 of an IRIG packet.
  - Expect `tvalid` low in the next cycle, both `tready` high, and `irig_drop_count` = 0.

Source files
------------

// File: rtl/irig_enc_stream_arbiter.sv
// Shares one 32-bit AXI-Stream DMA channel between buffered IRIG-B frames and encoder samples.
// Each item becomes one header-framed packet; ties are resolved round-robin at packet boundaries.
module irig_enc_stream_arbiter (
    input  logic         clk_50MHz,
    input  logic         reset,
    input  logic [163:0] s_irig_tdata,
    input  logic         s_irig_tvalid,
    output logic         s_irig_tready,
    input  logic [95:0]  s_enc_tdata,
    input  logic         s_enc_tvalid,
    output logic         s_enc_tready,
    output logic [31:0]  m_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic         m_axis_tlast,
    output logic [15:0]  irig_drop_count
);

    typedef enum logic [1:0] {StIdle, StSendIrig, StSendEnc} state_e;

    localparam logic        GrantIrig  = 1'b0;
    localparam logic        GrantEnc   = 1'b1;
    localparam logic [31:0] IrigHeader = 32'hA100_0006;
    localparam logic [31:0] EncHeader  = 32'hE100_0003;

    state_e         r_state;
    state_e         w_state_next;
    logic [2:0]     r_idx;
    logic           r_last_grant;
    logic [163:0]   r_irig_data;
    logic           r_irig_full;
    logic [95:0]    r_enc_data;
    logic           r_enc_full;
    logic [15:0]    r_drop_cnt;
    logic           w_beat_hs;
    logic           w_pkt_done;

    assign w_beat_hs       = m_axis_tvalid & m_axis_tready;
    assign w_pkt_done      = w_beat_hs & m_axis_tlast;
    assign s_irig_tready   = ~r_irig_full;
    assign s_enc_tready    = ~r_enc_full;
    assign irig_drop_count = r_drop_cnt;

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (r_irig_full && (!r_enc_full || r_last_grant == GrantEnc)) begin
                    w_state_next = StSendIrig;
                end else if (r_enc_full) begin
                    w_state_next = StSendEnc;
                end
            end
            StSendIrig, StSendEnc: begin
                if (w_pkt_done) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        m_axis_tvalid = (r_state != StIdle);
        m_axis_tdata  = 32'h0;
        m_axis_tlast  = 1'b0;
        case (r_state)
            StSendIrig: begin
                case (r_idx)
                    3'd0: m_axis_tdata = IrigHeader;
                    3'd1: m_axis_tdata = r_irig_data[31:0];
                    3'd2: m_axis_tdata = r_irig_data[63:32];
                    3'd3: m_axis_tdata = r_irig_data[95:64];
                    3'd4: m_axis_tdata = r_irig_data[127:96];
                    3'd5: m_axis_tdata = r_irig_data[159:128];
                    3'd6: begin
                        m_axis_tdata = {28'h0, r_irig_data[163:160]};
                        m_axis_tlast = 1'b1;
                    end
                    default: m_axis_tdata = 32'h0;
                endcase
            end
            StSendEnc: begin
                case (r_idx)
                    3'd0: m_axis_tdata = EncHeader;
                    3'd1: m_axis_tdata = r_enc_data[31:0];
                    3'd2: m_axis_tdata = r_enc_data[63:32];
                    3'd3: begin
                        m_axis_tdata = r_enc_data[95:64];
                        m_axis_tlast = 1'b1;
                    end
                    default: m_axis_tdata = 32'h0;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            r_idx        <= 3'd0;
            r_last_grant <= GrantEnc;
        end else if (r_state == StIdle) begin
            r_idx <= 3'd0;
            if (w_state_next == StSendIrig) begin
                r_last_grant <= GrantIrig;
            end else if (w_state_next == StSendEnc) begin
                r_last_grant <= GrantEnc;
            end
        end else if (w_beat_hs) begin
            r_idx <= w_pkt_done ? 3'd0 : r_idx + 3'd1;
        end
    end

    // Capture requires an empty buffer, release requires a full one, so they never collide.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            r_irig_full <= 1'b0;
            r_enc_full  <= 1'b0;
            r_drop_cnt  <= 16'h0;
        end else begin
            if (s_irig_tvalid && !r_irig_full) begin
                r_irig_full <= 1'b1;
            end else if (r_state == StSendIrig && w_pkt_done) begin
                r_irig_full <= 1'b0;
            end
            if (s_irig_tvalid && r_irig_full && r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            if (s_enc_tvalid && !r_enc_full) begin
                r_enc_full <= 1'b1;
            end else if (r_state == StSendEnc && w_pkt_done) begin
                r_enc_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_50MHz) begin
        if (s_irig_tvalid && !r_irig_full) begin
            r_irig_data <= s_irig_tdata;
        end
        if (s_enc_tvalid && !r_enc_full) begin
            r_enc_data <= s_enc_tdata;
        end
    end

endmodule

// File: tb/tb_irig_enc_stream_arbiter.sv
// Scoreboard bench for irig_enc_stream_arbiter: directed packets, drops, reset, stalls.
module tb_irig_enc_stream_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [163:0] s_irig_tdata;
    logic         s_irig_tvalid;
    logic         s_irig_tready;
    logic [95:0]  s_enc_tdata;
    logic         s_enc_tvalid;
    logic         s_enc_tready;
    logic [31:0]  m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic [15:0]  irig_drop_count;

    logic [32:0]  sb[$];
    int           errors = 0;
    int           checks = 0;
    bit           rnd_mode = 1'b0;

    localparam logic [163:0] Frame0 = 164'h5_0123456789ABCDEF_00112233_44556677_8899AABB;
    localparam logic [163:0] Frame1 = 164'hC_F0E1D2C3B4A59687_DEADBEEF_CAFEF00D_13579BDF;

    always #10 clk = ~clk;

    irig_enc_stream_arbiter dut (
        .clk_50MHz       (clk),
        .reset           (reset),
        .s_irig_tdata    (s_irig_tdata),
        .s_irig_tvalid   (s_irig_tvalid),
        .s_irig_tready   (s_irig_tready),
        .s_enc_tdata     (s_enc_tdata),
        .s_enc_tvalid    (s_enc_tvalid),
        .s_enc_tready    (s_enc_tready),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tlast    (m_axis_tlast),
        .irig_drop_count (irig_drop_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every presented beat must match the head of the queue, which also proves stall stability.
    always @(negedge clk) begin
        if (m_axis_tvalid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got tdata=%h tlast=%b, expected no beat",
                         m_axis_tdata, m_axis_tlast);
            end else begin
                check("beat", {31'h0, m_axis_tlast, m_axis_tdata}, {31'h0, sb[0]});
                if (m_axis_tready) void'(sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_mode) m_axis_tready = ($urandom_range(0, 7) != 0);
    endtask

    task automatic push_irig(input logic [163:0] d);
        sb.push_back({1'b0, 32'hA100_0006});
        sb.push_back({1'b0, d[31:0]});
        sb.push_back({1'b0, d[63:32]});
        sb.push_back({1'b0, d[95:64]});
        sb.push_back({1'b0, d[127:96]});
        sb.push_back({1'b0, d[159:128]});
        sb.push_back({1'b1, 28'h0, d[163:160]});
    endtask

    task automatic push_enc(input logic [63:0] ts, input logic [31:0] cnt);
        sb.push_back({1'b0, 32'hE100_0003});
        sb.push_back({1'b0, cnt});
        sb.push_back({1'b0, ts[31:0]});
        sb.push_back({1'b1, ts[63:32]});
    endtask

    task automatic send_irig(input logic [163:0] d);
        s_irig_tdata  = d;
        s_irig_tvalid = 1'b1;
        step();
        s_irig_tvalid = 1'b0;
    endtask

    task automatic send_enc(input logic [63:0] ts, input logic [31:0] cnt);
        for (int i = 0; i < 200 && !s_enc_tready; i++) step();
        check("enc_ready_wait", {63'h0, s_enc_tready}, 64'h1);
        s_enc_tdata  = {ts, cnt};
        s_enc_tvalid = 1'b1;
        step();
        s_enc_tvalid = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && sb.size() != 0; i++) step();
        check("drain", 64'(sb.size()), 64'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        s_irig_tdata  = '0;
        s_irig_tvalid = 1'b0;
        s_enc_tdata   = '0;
        s_enc_tvalid  = 1'b0;
        m_axis_tready = 1'b1;
        do_reset();

        @(negedge clk);
        check("rst_tvalid", {63'h0, m_axis_tvalid}, 64'h0);
        check("rst_tlast", {63'h0, m_axis_tlast}, 64'h0);
        check("rst_tdata", {32'h0, m_axis_tdata}, 64'h0);
        check("rst_irig_tready", {63'h0, s_irig_tready}, 64'h1);
        check("rst_enc_tready", {63'h0, s_enc_tready}, 64'h1);
        check("rst_drop", {48'h0, irig_drop_count}, 64'h0);

        // Single IRIG frame: header valid two cycles after the strobe.
        step();
        push_irig(Frame0);
        send_irig(Frame0);
        @(negedge clk);
        check("irig_lat_n", {63'h0, m_axis_tvalid}, 64'h0);
        check("irig_tready_low", {63'h0, s_irig_tready}, 64'h0);
        step();
        @(negedge clk);
        check("irig_lat_n1", {63'h0, m_axis_tvalid}, 64'h1);
        check("irig_hdr", {32'h0, m_axis_tdata}, 64'hA100_0006);
        drain(50);

        // Single encoder sample: tready low from capture to the cycle after tlast.
        push_enc(64'h0000_0001_8000_0000, 32'h1234_5678);
        send_enc(64'h0000_0001_8000_0000, 32'h1234_5678);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("enc_tready_busy", {63'h0, s_enc_tready}, 64'h0);
            step();
        end
        @(negedge clk);
        check("enc_tready_free", {63'h0, s_enc_tready}, 64'h1);
        drain(50);

        // Fresh reset: first tie goes to IRIG.
        do_reset();
        push_irig(Frame1);
        push_enc(64'h1111_2222_3333_4444, 32'hAAAA_5555);
        s_irig_tdata  = Frame1;
        s_enc_tdata   = {64'h1111_2222_3333_4444, 32'hAAAA_5555};
        s_irig_tvalid = 1'b1;
        s_enc_tvalid  = 1'b1;
        step();
        s_irig_tvalid = 1'b0;
        s_enc_tvalid  = 1'b0;
        drain(100);

        // After a lone IRIG grant, the next tie goes to the encoder.
        push_irig(Frame0);
        send_irig(Frame0);
        drain(50);
        push_enc(64'h0BAD_F00D_0000_0007, 32'h0000_0042);
        push_irig(Frame1);
        s_irig_tdata  = Frame1;
        s_enc_tdata   = {64'h0BAD_F00D_0000_0007, 32'h0000_0042};
        s_irig_tvalid = 1'b1;
        s_enc_tvalid  = 1'b1;
        step();
        s_irig_tvalid = 1'b0;
        s_enc_tvalid  = 1'b0;
        drain(100);

        // Drop: second strobe 3 cycles later while the output is stalled.
        m_axis_tready = 1'b0;
        push_irig(Frame0);
        send_irig(Frame0);
        step();
        step();
        send_irig(Frame1);
        @(negedge clk);
        check("drop_one", {48'h0, irig_drop_count}, 64'h1);
        repeat (4) step();
        m_axis_tready = 1'b1;
        drain(50);

        // Strobe coinciding with the tlast handshake is dropped.
        push_irig(Frame1);
        send_irig(Frame1);
        repeat (7) step();
        s_irig_tdata  = Frame0;
        s_irig_tvalid = 1'b1;
        @(negedge clk);
        check("tlast_tready_low", {63'h0, s_irig_tready}, 64'h0);
        check("tlast_beat", {63'h0, m_axis_tlast}, 64'h1);
        step();
        s_irig_tvalid = 1'b0;
        @(negedge clk);
        check("drop_at_tlast", {48'h0, irig_drop_count}, 64'h2);
        check("tready_after_tlast", {63'h0, s_irig_tready}, 64'h1);
        repeat (4) step();
        drain(10);

        // Reset during beat 3 of an IRIG packet, with the encoder buffer also loaded.
        sb.push_back({1'b0, 32'hA100_0006});
        sb.push_back({1'b0, Frame0[31:0]});
        sb.push_back({1'b0, Frame0[63:32]});
        send_irig(Frame0);
        s_enc_tdata  = {64'h5555_6666_7777_8888, 32'h9999_0000};
        s_enc_tvalid = 1'b1;
        step();
        s_enc_tvalid = 1'b0;
        step();
        step();
        reset = 1'b1;
        @(negedge clk);
        check("midpkt_enc_full", {63'h0, s_enc_tready}, 64'h0);
        step();
        @(negedge clk);
        check("midpkt_tvalid", {63'h0, m_axis_tvalid}, 64'h0);
        check("midpkt_irig_tready", {63'h0, s_irig_tready}, 64'h1);
        check("midpkt_enc_tready", {63'h0, s_enc_tready}, 64'h1);
        check("midpkt_drop", {48'h0, irig_drop_count}, 64'h0);
        step();
        reset = 1'b0;
        repeat (6) step();
        drain(10);

        // 1000 packets with random backpressure.
        rnd_mode = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            logic [163:0] d;
            logic [63:0]  ts;
            logic [31:0]  cnt;
            for (int w = 0; w < 6; w++) d = {d[131:0], $urandom()};
            ts  = {$urandom(), $urandom()};
            cnt = $urandom();
            if (p % 2 == 0) begin
                push_irig(d);
                send_irig(d);
            end else begin
                push_enc(ts, cnt);
                send_enc(ts, cnt);
            end
            drain(200);
        end
        rnd_mode      = 1'b0;
        m_axis_tready = 1'b1;

        // Sustained overflow saturates the drop counter.
        do_reset();
        m_axis_tready = 1'b0;
        push_irig(Frame0);
        s_irig_tdata  = Frame0;
        s_irig_tvalid = 1'b1;
        repeat (65535) step();
        s_irig_tvalid = 1'b0;
        @(negedge clk);
        check("drop_fffe", {48'h0, irig_drop_count}, 64'hFFFE);
        step();
        s_irig_tvalid = 1'b1;
        repeat (3) step();
        s_irig_tvalid = 1'b0;
        @(negedge clk);
        check("drop_sat", {48'h0, irig_drop_count}, 64'hFFFF);
        step();
        m_axis_tready = 1'b1;
        drain(50);
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
